// File: rtl/usb_line_state_monitor.sv
// USB bus-state monitor: run-length counts SE0/J/K on the synchronised
// line and decides bus reset, suspend and resume from programmable thresholds.
module usb_line_state_monitor #(
    parameter int CNT_W          = 20,
    parameter int RESET_CYCLES   = 480000,
    parameter int SUSPEND_CYCLES = 144000,
    parameter int RESUME_CYCLES  = 960
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       j,
    input  logic       se0,
    output logic [1:0] line_state,
    output logic [1:0] bus_state,
    output logic       usb_rst,
    output logic       suspend,
    output logic       resume,
    output logic       rst_start,
    output logic       wake
);

    typedef enum logic [1:0] {
        CODE_SE0 = 2'd0,
        CODE_J   = 2'd1,
        CODE_K   = 2'd2
    } code_e;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_RESET   = 2'd1,
        ST_SUSPEND = 2'd2,
        ST_RESUME  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_TH  = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] SUS_TH  = CNT_W'(SUSPEND_CYCLES);
    localparam logic [CNT_W-1:0] RES_TH  = CNT_W'(RESUME_CYCLES);

    code_e            cur_code;
    code_e            prev_code;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt;
    state_e           state;
    state_e           state_nxt;
    logic             rst_start_q;
    logic             wake_q;
    logic             hit_rst;
    logic             hit_sus;
    logic             hit_res;

    // Classify the current sample; SE0 overrides J.
    always_comb begin
        cur_code = CODE_K;
        if (se0) begin
            cur_code = CODE_SE0;
        end else if (j) begin
            cur_code = CODE_J;
        end
    end

    // Run length this edge will store; saturates so a long run never wraps.
    always_comb begin
        nxt = CNT_ONE;
        if (cur_code == prev_code) begin
            nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        end
    end

    // Equality against the new run length fires once per run.
    always_comb begin
        hit_rst = (cur_code == CODE_SE0) && (nxt == RST_TH);
        hit_sus = (cur_code == CODE_J) && (nxt == SUS_TH);
        hit_res = (cur_code == CODE_K) && (nxt == RES_TH);
    end

    // Bus-state transitions.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_ACTIVE: begin
                if (hit_rst) begin
                    state_nxt = ST_RESET;
                end else if (hit_sus) begin
                    state_nxt = ST_SUSPEND;
                end
            end
            ST_RESET: begin
                if (cur_code != CODE_SE0) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_SUSPEND: begin
                if (hit_res) begin
                    state_nxt = ST_RESUME;
                end else if (hit_rst) begin
                    state_nxt = ST_RESET;
                end
            end
            ST_RESUME: begin
                if (cur_code != CODE_K) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            default: state_nxt = ST_ACTIVE;
        endcase
    end

    // Line code history and run-length counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_code <= CODE_J;
            cnt       <= '0;
        end else begin
            prev_code <= cur_code;
            cnt       <= nxt;
        end
    end

    // State register plus one-cycle entry pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ACTIVE;
            rst_start_q <= 1'b0;
            wake_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            rst_start_q <= (state_nxt == ST_RESET) && (state != ST_RESET);
            wake_q      <= (state_nxt == ST_RESUME) && (state != ST_RESUME);
        end
    end

    assign line_state = prev_code;
    assign bus_state  = state;
    assign usb_rst    = (state == ST_RESET);
    assign suspend    = (state == ST_SUSPEND);
    assign resume     = (state == ST_RESUME);
    assign rst_start  = rst_start_q;
    assign wake       = wake_q;

endmodule
